// File: rtl/flit_link_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : types
// Flit format shared by the link arbiter and its flit sources.
// Revision : 1.0  initial release
// ============================================================================
package types;

    localparam int c_PAYLOAD_W = 32;

    typedef enum logic [1:0] {
        HEAD   = 2'd0,
        BODY   = 2'd1,
        TAIL   = 2'd2,
        SINGLE = 2'd3
    } flittype_t;

    typedef struct packed {
        flittype_t              ftype;
        logic [c_PAYLOAD_W-1:0] payload;
    } flit_t;

    function automatic flittype_t flit_type(input flit_t f);
        return f.ftype;
    endfunction

    // HEAD and SINGLE are the only flits that may open a link grant.
    function automatic logic is_open(input flittype_t t);
        return (t == HEAD) || (t == SINGLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/flit_link_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Combinational round-robin pick: first eligible index at or after i_start.
// Revision : 1.0  initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_PORTS = 3
) (
    input  logic [NUM_PORTS-1:0]         i_eligible,
    input  logic [$clog2(NUM_PORTS)-1:0] i_start,
    output logic [NUM_PORTS-1:0]         o_grant,
    output logic [$clog2(NUM_PORTS)-1:0] o_grant_idx,
    output logic                         o_any
);

    localparam int c_PTR_W = $clog2(NUM_PORTS);
    localparam int c_SUM_W = c_PTR_W + 1;

    logic [c_SUM_W-1:0] w_sum;
    logic [c_PTR_W-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_sum = {1'b0, i_start} + c_SUM_W'(k);
            if (w_sum >= c_SUM_W'(NUM_PORTS)) begin
                w_sum = w_sum - c_SUM_W'(NUM_PORTS);
            end
            w_idx = w_sum[c_PTR_W-1:0];
            if (!o_any && i_eligible[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/flit_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : flit_link_arbiter
// Packet-atomic round-robin arbiter of NUM_PORTS flit sources onto one link.
// Optional owner-stall watchdog enabled by defining ARB_WATCHDOG_EN.
// Revision : 1.0  initial release
// ============================================================================
module flit_link_arbiter
    import types::*;
#(
    parameter int NUM_PORTS      = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         nocclk,
    input  logic                         rst,
    input  flit_t [NUM_PORTS-1:0]        in_flit,
    input  logic  [NUM_PORTS-1:0]        in_valid,
    output logic  [NUM_PORTS-1:0]        in_ready,
    output flit_t                        out_flit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NUM_PORTS)-1:0] owner,
    output logic                         busy,
`ifdef ARB_WATCHDOG_EN
    output logic                         seq_err,
    output logic                         timeout_err
`else
    output logic                         seq_err
`endif
);

    localparam int         c_PTR_W  = $clog2(NUM_PORTS);
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;

    logic [0:0]           r_state;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_PTR_W-1:0]   r_owner;

    logic [NUM_PORTS-1:0] w_eligible;
    logic [NUM_PORTS-1:0] w_stray;
    logic [NUM_PORTS-1:0] w_grant;
    logic [c_PTR_W-1:0]   w_grant_idx;
    logic                 w_any;
    logic                 w_owner_valid;
    logic                 w_owner_bad;
    logic                 w_xfer;
    logic                 w_timeout;
    flittype_t            w_xfer_type;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        return (int'(p) == NUM_PORTS - 1) ? '0 : p + c_PTR_W'(1);
    endfunction

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_classify
        assign w_eligible[i] = in_valid[i] &&  is_open(flit_type(in_flit[i]));
        assign w_stray[i]    = in_valid[i] && !is_open(flit_type(in_flit[i]));
    end

    rr_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .i_eligible  (w_eligible),
        .i_start     (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    // An owner re-opening a packet mid-transfer is refused, not forwarded.
    assign w_owner_valid = in_valid[r_owner];
    assign w_owner_bad   = w_owner_valid && is_open(flit_type(in_flit[r_owner]));

    always_comb begin
        out_flit  = in_flit[w_grant_idx];
        out_valid = 1'b0;
        in_ready  = '0;
        seq_err   = 1'b0;
        if (!rst) begin
            if (r_state == c_IDLE) begin
                out_valid = w_any;
                in_ready  = w_grant & {NUM_PORTS{out_ready}};
                seq_err   = |w_stray;
            end else begin
                out_flit          = in_flit[r_owner];
                out_valid         = w_owner_valid && !w_owner_bad;
                in_ready[r_owner] = out_ready && !w_owner_bad;
                seq_err           = w_owner_bad;
            end
        end
    end

    assign w_xfer      = out_valid && out_ready;
    assign w_xfer_type = flit_type(out_flit);
    assign owner       = r_owner;
    assign busy        = (r_state == c_LOCKED);

`ifdef ARB_WATCHDOG_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WD_W-1:0] r_wd_cnt;

    assign w_timeout   = (r_state == c_LOCKED) && !w_owner_valid &&
                         (r_wd_cnt == c_WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = w_timeout;

    always_ff @(posedge nocclk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if ((r_state != c_LOCKED) || w_xfer || w_timeout) begin
            r_wd_cnt <= '0;
        end else if (!w_owner_valid) begin
            r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge nocclk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else if (r_state == c_IDLE) begin
            if (w_xfer) begin
                r_owner  <= w_grant_idx;
                r_rr_ptr <= f_next_ptr(w_grant_idx);
                if (w_xfer_type == HEAD) begin
                    r_state <= c_LOCKED;
                end
            end
        end else if (w_xfer && (w_xfer_type == TAIL)) begin
            r_state <= c_IDLE;
        end else if (w_timeout) begin
            r_state  <= c_IDLE;
            r_rr_ptr <= f_next_ptr(r_owner);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flit_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_flit_link_arbiter
// Directed and randomized bench for flit_link_arbiter against a cycle model.
// Revision : 1.0  initial release
// ============================================================================
module tb_flit_link_arbiter;
    import types::*;

    localparam int NUM_PORTS      = 3;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int PTR_W          = $clog2(NUM_PORTS);

    logic                  nocclk = 1'b0;
    logic                  rst;
    flit_t [NUM_PORTS-1:0] in_flit;
    logic  [NUM_PORTS-1:0] in_valid;
    logic  [NUM_PORTS-1:0] in_ready;
    flit_t                 out_flit;
    logic                  out_valid;
    logic                  out_ready;
    logic  [PTR_W-1:0]     owner;
    logic                  busy;
    logic                  seq_err;
`ifdef ARB_WATCHDOG_EN
    logic                  timeout_err;
`endif

    always #5 nocclk = ~nocclk;

    flit_link_arbiter #(
        .NUM_PORTS      (NUM_PORTS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .nocclk      (nocclk),
        .rst         (rst),
        .in_flit     (in_flit),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_flit    (out_flit),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .owner       (owner),
        .busy        (busy),
`ifdef ARB_WATCHDOG_EN
        .seq_err     (seq_err),
        .timeout_err (timeout_err)
`else
        .seq_err     (seq_err)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: packet owner, lock flag, round-robin start, stall count.
    bit m_locked;
    int m_owner, m_rr, m_stall;

    // Observations of the DUT per directed scenario.
    int log_src[$];
    int log_cyc[$];
    int obs_busy, obs_seq, obs_to, cyc;
    logic [NUM_PORTS-1:0] acc_mask;
    flit_t src_q[NUM_PORTS][$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic flit_t mk(input flittype_t t, input logic [31:0] d);
        flit_t f;
        f.ftype   = t;
        f.payload = d;
        return f;
    endfunction

    function automatic bit opener(input flittype_t t);
        return (t == HEAD) || (t == SINGLE);
    endfunction

    task automatic clear_obs();
        log_src.delete();
        log_cyc.delete();
        obs_busy = 0;
        obs_seq  = 0;
        obs_to   = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '1;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) in_flit[i] = mk(HEAD, 32'(i));
        @(negedge nocclk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_seq_err", seq_err, 0);
        check_eq("rst_owner", owner, 0);
`ifdef ARB_WATCHDOG_EN
        check_eq("rst_timeout_err", timeout_err, 0);
`endif
        m_locked = 0;
        m_owner  = 0;
        m_rr     = 0;
        m_stall  = 0;
        @(posedge nocclk);
        #1;
        rst      = 1'b0;
        in_valid = '0;
    endtask

    // Check one cycle of DUT outputs against the model, then advance both.
    task automatic cycle();
        int win;
        logic [NUM_PORTS-1:0] e_ready;
        logic e_valid, e_seq, e_to;
        flit_t e_flit;
        flittype_t t;
        @(negedge nocclk);
        win = -1; e_ready = '0; e_valid = 0; e_seq = 0; e_to = 0; e_flit = '0;
        if (!m_locked) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                int p;
                p = (m_rr + k) % NUM_PORTS;
                if (win < 0 && in_valid[p] && opener(in_flit[p].ftype)) win = p;
            end
            for (int i = 0; i < NUM_PORTS; i++)
                if (in_valid[i] && !opener(in_flit[i].ftype)) e_seq = 1;
            if (win >= 0) begin
                e_valid      = 1;
                e_flit       = in_flit[win];
                e_ready[win] = out_ready;
            end
        end else begin
            t = in_flit[m_owner].ftype;
            if (in_valid[m_owner] && opener(t)) begin
                e_seq = 1;
            end else begin
                win              = m_owner;
                e_valid          = in_valid[m_owner];
                e_flit           = in_flit[m_owner];
                e_ready[m_owner] = out_ready;
            end
        end
`ifdef ARB_WATCHDOG_EN
        if (m_locked && !in_valid[m_owner] && (m_stall + 1 == TIMEOUT_CYCLES)) e_to = 1;
        check_eq("timeout_err", timeout_err, e_to);
        if (timeout_err === 1'b1) obs_to++;
`endif
        check_eq("out_valid", out_valid, e_valid);
        check_eq("in_ready", in_ready, e_ready);
        check_eq("seq_err", seq_err, e_seq);
        check_eq("busy", busy, m_locked);
        check_eq("owner", owner, m_owner);
        if (e_valid) check_eq("out_flit", out_flit, e_flit);

        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            int src;
            src = -1;
            for (int i = 0; i < NUM_PORTS; i++) if (in_ready[i] === 1'b1) src = i;
            log_src.push_back(src);
            log_cyc.push_back(cyc);
        end
        if (busy === 1'b1) obs_busy++;
        if (seq_err === 1'b1) obs_seq++;
        acc_mask = in_ready & in_valid;

        if (e_valid && out_ready) begin
            if (!m_locked) begin
                m_owner = win;
                m_rr    = (win + 1) % NUM_PORTS;
                if (e_flit.ftype == HEAD) m_locked = 1;
            end else if (e_flit.ftype == TAIL) begin
                m_locked = 0;
            end
            m_stall = 0;
        end else if (e_to) begin
            m_locked = 0;
            m_rr     = (m_owner + 1) % NUM_PORTS;
            m_stall  = 0;
        end else if (m_locked && !in_valid[m_owner]) begin
            m_stall++;
        end
        cyc++;
        @(posedge nocclk);
        #1;
    endtask

    // Sources present their queue heads and pop on an accepted flit.
    task automatic run_queues(input int max_cycles, input bit must_drain);
        int n, left;
        n = 0;
        left = 0;
        for (int i = 0; i < NUM_PORTS; i++) left += src_q[i].size();
        while (left > 0 && n < max_cycles) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                in_valid[i] = (src_q[i].size() > 0);
                if (src_q[i].size() > 0) in_flit[i] = src_q[i][0];
            end
            cycle();
            for (int i = 0; i < NUM_PORTS; i++)
                if (acc_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            n++;
            left = 0;
            for (int i = 0; i < NUM_PORTS; i++) left += src_q[i].size();
        end
        if (must_drain) check_eq("drain_budget", left, 0);
        in_valid = '0;
    endtask

    initial begin
        int exp1[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        int exp2[6] = '{1, 1, 1, 1, 0, 0};
        int exp3[3] = '{0, 2, 0};
        cyc = 0;
        in_valid = '0;
        out_ready = 1'b1;
        in_flit = '0;
        do_reset();

        // Three 3-flit packets, full link rate.
        clear_obs();
        for (int i = 0; i < NUM_PORTS; i++) begin
            src_q[i].push_back(mk(HEAD, 32'h100 + 32'(i)));
            src_q[i].push_back(mk(BODY, 32'h200 + 32'(i)));
            src_q[i].push_back(mk(TAIL, 32'h300 + 32'(i)));
        end
        run_queues(40, 1);
        check_eq("s1_count", log_src.size(), 9);
        for (int i = 0; i < 9 && i < log_src.size(); i++) check_eq("s1_order", log_src[i], exp1[i]);
        check_eq("s1_busy_cycles", obs_busy, 6);

        // Source 0 HEAD waits behind source 1's open packet.
        do_reset();
        clear_obs();
        src_q[1].push_back(mk(HEAD, 32'h11));
        src_q[1].push_back(mk(BODY, 32'h12));
        src_q[1].push_back(mk(BODY, 32'h13));
        src_q[1].push_back(mk(TAIL, 32'h14));
        run_queues(1, 0);
        src_q[0].push_back(mk(HEAD, 32'h01));
        src_q[0].push_back(mk(TAIL, 32'h02));
        run_queues(40, 1);
        check_eq("s2_count", log_src.size(), 6);
        for (int i = 0; i < 6 && i < log_src.size(); i++) check_eq("s2_order", log_src[i], exp2[i]);
        if (log_cyc.size() >= 5) check_eq("s2_next_cycle", log_cyc[4] - log_cyc[3], 1);

        // SINGLE flits on 0 and 2 with the pointer parked at 1.
        do_reset();
        clear_obs();
        src_q[0].push_back(mk(SINGLE, 32'hA0));
        run_queues(10, 1);
        src_q[0].push_back(mk(SINGLE, 32'hA1));
        src_q[2].push_back(mk(SINGLE, 32'hA2));
        run_queues(10, 1);
        check_eq("s3_count", log_src.size(), 3);
        for (int i = 0; i < 3 && i < log_src.size(); i++) check_eq("s3_order", log_src[i], exp3[i]);
        check_eq("s3_busy_cycles", obs_busy, 0);

        // Backpressure on a HEAD offer.
        do_reset();
        clear_obs();
        src_q[0].push_back(mk(HEAD, 32'hBEEF));
        src_q[0].push_back(mk(TAIL, 32'hCAFE));
        out_ready = 1'b0;
        run_queues(5, 0);
        check_eq("s4_no_xfer", log_src.size(), 0);
        check_eq("s4_busy_cycles", obs_busy, 0);
        out_ready = 1'b1;
        run_queues(1, 0);
        check_eq("s4_xfer_on_ready", log_src.size(), 1);
        run_queues(10, 1);

        // Stray BODY in IDLE.
        do_reset();
        clear_obs();
        src_q[1].push_back(mk(BODY, 32'hBAD));
        run_queues(1, 0);
        src_q[1].delete();
        run_queues(1, 0);
        cycle();
        check_eq("s5_seq_pulses", obs_seq, 1);
        check_eq("s5_no_xfer", log_src.size(), 0);

        // Mid-packet reset abandons the packet.
        do_reset();
        clear_obs();
        src_q[2].push_back(mk(HEAD, 32'h21));
        run_queues(5, 1);
        do_reset();
        clear_obs();
        src_q[2].push_back(mk(BODY, 32'h22));
        run_queues(1, 0);
        src_q[2].delete();
        check_eq("s7_after_rst_seq", obs_seq, 1);

`ifdef ARB_WATCHDOG_EN
        // Owner stalls after its HEAD until the watchdog releases the link.
        do_reset();
        clear_obs();
        src_q[0].push_back(mk(HEAD, 32'hD0));
        run_queues(5, 1);
        for (int i = 0; i < TIMEOUT_CYCLES; i++) cycle();
        check_eq("s6_timeout_pulses", obs_to, 1);
        check_eq("s6_idle", busy, 0);
        clear_obs();
        src_q[0].push_back(mk(SINGLE, 32'hD1));
        src_q[1].push_back(mk(SINGLE, 32'hD2));
        run_queues(10, 1);
        if (log_src.size() > 0) check_eq("s6_rr_after_timeout", log_src[0], 1);
`endif

        // Randomized traffic with occasional resets.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            for (int i = 0; i < NUM_PORTS; i++) begin
                in_valid[i] = ($urandom_range(0, 99) < 70);
                in_flit[i]  = mk(flittype_t'(2'($urandom_range(0, 3))), $urandom());
            end
            out_ready = ($urandom_range(0, 99) < 75);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire

// File: doc/flit_link_arbiter.md
FLIT_LINK_ARBITER -- requirements
Module: flit_link_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 3, is the number of flit sources competing for one outgoing link; the legal range is 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, is the owner-stall limit used only when ARB_WATCHDOG_EN is defined.
REQ-003 Port nocclk, input, 1 bit, is the single clock; every register samples on its rising edge.
REQ-004 Port rst, input, 1 bit, is the reset: asynchronous, active-high.
REQ-005 Port in_flit, input, NUM_PORTS x types::flit_t, carries the flit from each source.
REQ-006 Port in_valid, input, NUM_PORTS bits, is the per-source flit valid.
REQ-007 Port in_ready, output, NUM_PORTS bits, is the per-source flit accept.
REQ-008 Port out_flit, output, types::flit_t, is the flit on the shared link.
REQ-009 Port out_valid, output, 1 bit, is the shared link valid.
REQ-010 Port out_ready, input, 1 bit, is the shared link ready from downstream.
REQ-011 Port owner, output, $clog2(NUM_PORTS) bits, is the index of the source currently holding the link.
REQ-012 Port busy, output, 1 bit, is high while a packet is mid-transfer (state LOCKED).
REQ-013 Port seq_err, output, 1 bit, is a one-cycle pulse on a protocol violation.
REQ-014 Port timeout_err, output, 1 bit, is a one-cycle pulse on a watchdog release; it is present only with ARB_WATCHDOG_EN.

Function
REQ-015 The arbiter SHALL be packet-atomic: once a HEAD flit from source i is transferred, only source i is served until its TAIL flit is transferred.
REQ-016 The FSM SHALL have two states: IDLE and LOCKED.
- IDLE -> LOCKED on transfer of a HEAD flit.
- LOCKED -> IDLE on transfer of a TAIL flit.
- A SINGLE flit transfer leaves the FSM in IDLE.
REQ-017 A transfer SHALL be defined as out_valid && out_ready in the same cycle.
REQ-018 In IDLE, a source is eligible when in_valid[i] is high and its flit type is HEAD or SINGLE.
REQ-019 In IDLE, the grant SHALL be round-robin over eligible sources, starting at rr_ptr and wrapping from NUM_PORTS-1 to 0.
REQ-020 The grant SHALL be combinational with zero latency: out_flit, out_valid and in_ready[granted] follow the winner in the same cycle.
REQ-021 rr_ptr SHALL update to (granted+1) mod NUM_PORTS only on a HEAD or SINGLE transfer; a grant with out_ready low SHALL NOT move rr_ptr or change state.
REQ-022 In LOCKED:
- out_flit = in_flit[owner] and out_valid = in_valid[owner];
- in_ready[owner] = out_ready;
- every other in_ready SHALL be 0.
REQ-023 in_ready[i] SHALL be 0 for every i that is not granted or owner.
REQ-024 Protocol violations SHALL pulse seq_err for one cycle, and the offending flit SHALL NOT be accepted:
- a valid BODY or TAIL flit from any source while in IDLE;
- a valid HEAD or SINGLE flit from the owner while in LOCKED.
REQ-025 owner SHALL hold its value through LOCKED and SHALL retain the last winner while in IDLE.

Reset
REQ-026 While rst is high, the block SHALL hold:
- state = IDLE, rr_ptr = 0, owner = 0;
- busy = 0, seq_err = 0, timeout_err = 0;
- watchdog counter = 0;
- out_valid = 0 and in_ready = 0 regardless of inputs.
REQ-027 A reset asserted mid-packet SHALL abandon the packet; after release, the next served flit SHALL be a HEAD or SINGLE flit.

Configuration
REQ-028 With ARB_WATCHDOG_EN defined, the watchdog SHALL behave as follows:
- a counter increments each LOCKED cycle in which in_valid[owner] is low;
- the counter clears on any owner transfer;
- on reaching TIMEOUT_CYCLES, the FSM returns to IDLE, timeout_err pulses one cycle, and rr_ptr = (owner+1) mod NUM_PORTS.
REQ-029 Without ARB_WATCHDOG_EN, there SHALL be no counter and no timeout_err port, and LOCKED is held indefinitely.

Structure
REQ-030 The package types SHALL hold flit_t, the flittype_t enumeration {HEAD, BODY, TAIL, SINGLE}, and the flit-type field accessor; the arbiter SHALL NOT redefine them.
REQ-031 The round-robin pick SHALL be a sub-module rr_picker: NUM_PORTS-bit eligible mask and start pointer in, one-hot grant and index out, purely combinational.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Sources 0,1,2 each hold a 3-flit packet, out_ready = 1, after reset -> packet order 0,1,2, with no interleaving and busy high for 2 cycles per packet.
- Source 1 in LOCKED after its HEAD, source 0 presents a HEAD -> in_ready[0] = 0 until source 1's TAIL transfers; the grant goes to 0 in the following cycle.
- SINGLE flits valid on sources 0 and 2 with rr_ptr = 1 -> source 2 is served first, rr_ptr = 0, then source 0; busy stays 0 throughout.
- out_ready low for 5 cycles during a HEAD offer -> the same flit is held stable, rr_ptr and state are unchanged, and the transfer occurs on the first ready cycle.
- A BODY flit valid on source 1 in IDLE -> seq_err = 1 for one cycle, in_ready[1] = 0 and out_valid = 0.
- With ARB_WATCHDOG_EN and TIMEOUT_CYCLES = 8, owner 0 drops valid after its HEAD -> timeout_err pulses in the 8th stall cycle, the state is IDLE, and rr_ptr = 1.
